// File: rtl/cnn_layer_sequencer_pkg.sv
// rtl/cnn_layer_sequencer_pkg.sv - shared state encodings and stage constants for the layer sequencer
package cnn_layer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_TIMEOUT    = 4096;
  localparam int DEF_CNT_W      = 20;

  localparam int STG_CONV1 = 0;
  localparam int STG_POOL1 = 1;
  localparam int STG_CONV2 = 2;
  localparam int STG_POOL2 = 3;
  localparam int STG_FC    = 4;

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// rtl/cnn_layer_sequencer_watchdog.sv - loadable up/down counter with clear and expiry flag
module seq_watchdog #(
  parameter int           W        = 12,
  parameter logic [W-1:0] TERMINAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  logic         up,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  // Up-counting expires on TERMINAL, down-counting on zero.
  assign expired = up ? (count == TERMINAL) : (count == '0);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - frame-level scheduler firing each CNN stage in turn with a per-stage watchdog
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_flag,
  input  logic [NUM_STAGES-1:0] stage_end,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  end_flag,
  output logic                  error,
  output logic [CNT_W-1:0]      frame_cycles
);

  localparam int               WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t       state, state_next;
  logic [IDX_W-1:0] idx_next;
  logic [CNT_W-1:0] frame_cnt, cnt_inc;
  logic             accept, fire, done, timeout;
  logic             wd_clear, wd_en, wd_expired;

  seq_watchdog #(
    .W        (WD_W),
    .TERMINAL (WD_W'(TIMEOUT - 1))
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (wd_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (wd_en),
    .up         (1'b1),
    .expired    (wd_expired)
  );

  assign cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;

  always_comb begin
    state_next = state;
    idx_next   = stage_idx;
    accept     = 1'b0;
    fire       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_flag) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        fire       = 1'b1;
        wd_clear   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // A matching end on the final watchdog cycle still counts as success.
        if (stage_end[stage_idx]) begin
          if (stage_idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = stage_idx + 1'b1;
            state_next = ST_FIRE;
          end
        end else if (wd_expired) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      stage_idx    <= '0;
      stage_start  <= '0;
      end_flag     <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      frame_cnt    <= '0;
      frame_cycles <= '0;
    end else begin
      state       <= state_next;
      stage_idx   <= idx_next;
      stage_start <= fire ? (NUM_STAGES'(1) << stage_idx) : '0;
      end_flag    <= done;
      frame_cnt   <= accept ? '0 : (busy ? cnt_inc : frame_cnt);
      // The end_flag cycle is still busy, so the latched count includes it.
      if (end_flag) begin
        busy         <= 1'b0;
        frame_cycles <= cnt_inc;
      end
      if (timeout) begin
        busy  <= 1'b0;
        error <= 1'b1;
      end
      if (accept) begin
        busy  <= 1'b1;
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - randomized self-checking bench for cnn_layer_sequencer against a cycle-schedule model
module tb_cnn_layer_sequencer;

  localparam int NS     = 5;
  localparam int TO     = 128;
  localparam int CW     = 9;
  localparam int IW     = $clog2(NS);
  localparam int FC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_flag = 1'b0;
  logic [NS-1:0] stage_end = '0;
  logic [NS-1:0] stage_start;
  logic          busy;
  logic [IW-1:0] stage_idx;
  logic          end_flag;
  logic          error;
  logic [CW-1:0] frame_cycles;

  cnn_layer_sequencer #(
    .NUM_STAGES (NS),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_flag   (start_flag),
    .stage_end    (stage_end),
    .stage_start  (stage_start),
    .busy         (busy),
    .stage_idx    (stage_idx),
    .end_flag     (end_flag),
    .error        (error),
    .frame_cycles (frame_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Stage responder settings: dly[k] < 0 means stage k never answers.
  int            dly[NS]      = '{default: 50};
  int            end_at[NS]   = '{default: -1};
  int            inj_cyc[2]   = '{default: -1};
  logic [NS-1:0] inj_mask[2]  = '{default: '0};

  int   pulse_cyc[$];
  int   pulse_idx[$];
  int   endf_cyc[$];
  int   busy_cnt = 0;
  int   err_cyc  = -1;
  logic prev_err = 1'b0;

  int exp_pulse[$];
  int exp_end, exp_err, exp_idx, exp_busy, fin, s_cur;
  int exp_fc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor and stage responder, both working on the falling edge.
  initial begin
    int            idx;
    logic [NS-1:0] se;
    forever begin
      @(negedge clk);
      if (stage_start != '0) begin
        idx = 99;
        if ($onehot(stage_start))
          for (int k = 0; k < NS; k++) if (stage_start[k]) idx = k;
        pulse_cyc.push_back(cyc);
        pulse_idx.push_back(idx);
        if (idx < NS && dly[idx] >= 0) end_at[idx] = cyc + dly[idx];
      end
      if (end_flag) endf_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      if (error && !prev_err) err_cyc = cyc;
      prev_err = error;
      se = '0;
      for (int k = 0; k < NS; k++) if (end_at[k] == cyc) se[k] = 1'b1;
      for (int i = 0; i < 2; i++) if (inj_cyc[i] == cyc) se = se | inj_mask[i];
      stage_end = se;
    end
  end

  // Schedule model: start at s, pulse k lands 2 cycles after the previous end, done 2 after last end.
  task automatic model_frame(input int s);
    int p;
    exp_pulse.delete();
    exp_end = -1;
    exp_err = -1;
    p = s + 2;
    for (int k = 0; k < NS; k++) begin
      exp_pulse.push_back(p);
      exp_idx = k;
      if (dly[k] < 0 || dly[k] >= TO) begin
        exp_err = p + TO;
        break;
      end
      if (k == NS - 1) exp_end = p + dly[k] + 2;
      else p = p + dly[k] + 2;
    end
    if (exp_err >= 0) begin
      fin      = exp_err;
      exp_busy = exp_err - s - 1;
    end else begin
      fin      = exp_end;
      exp_busy = exp_end - s;
      exp_fc   = (exp_end - s > FC_MAX) ? FC_MAX : exp_end - s;
    end
  endtask

  task automatic begin_frame(input string tag, input int s);
    pulse_cyc.delete();
    pulse_idx.delete();
    endf_cyc.delete();
    busy_cnt = 0;
    err_cyc  = -1;
    for (int k = 0; k < NS; k++) end_at[k] = -1;
    model_frame(s);
    s_cur = s;
    wait_cycle(s);
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    check($sformatf("%s_err_clr", tag), error, 0);
    check($sformatf("%s_busy_rise", tag), busy, 1);
  endtask

  task automatic finish_frame(input string tag, input int extra);
    if (extra > 0) begin
      wait_cycle(extra);
      start_flag = 1'b1;
      @(negedge clk);
      start_flag = 1'b0;
    end
    wait_cycle(fin + 3);
    check($sformatf("%s_npulse", tag), pulse_cyc.size(), exp_pulse.size());
    for (int i = 0; i < exp_pulse.size() && i < pulse_cyc.size(); i++) begin
      check($sformatf("%s_pcyc%0d", tag, i), pulse_cyc[i], exp_pulse[i]);
      check($sformatf("%s_pidx%0d", tag, i), pulse_idx[i], i);
    end
    check($sformatf("%s_nend", tag), endf_cyc.size(), (exp_end >= 0) ? 1 : 0);
    check($sformatf("%s_end_cyc", tag), (endf_cyc.size() > 0) ? endf_cyc[0] : -1, exp_end);
    check($sformatf("%s_err_cyc", tag), err_cyc, exp_err);
    check($sformatf("%s_error", tag), error, (exp_err >= 0) ? 1 : 0);
    check($sformatf("%s_idx", tag), stage_idx, exp_idx);
    check($sformatf("%s_busy_low", tag), busy, 0);
    check($sformatf("%s_busy_cnt", tag), busy_cnt, exp_busy);
    check($sformatf("%s_fc", tag), frame_cycles, exp_fc);
    inj_cyc = '{default: -1};
  endtask

  initial begin
    int r, extra;
    wait_cycle(3);
    check("rst_start", stage_start, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", stage_idx, 0);
    check("rst_end", end_flag, 0);
    check("rst_err", error, 0);
    check("rst_fc", frame_cycles, 0);
    wait_cycle(5);
    reset = 1'b0;

    dly = '{default: 50};
    begin_frame("nom", 10);
    finish_frame("nom", 0);
    check("nom_p4_abs", (pulse_cyc.size() == 5) ? pulse_cyc[4] : -1, 220);
    check("nom_end_abs", (endf_cyc.size() > 0) ? endf_cyc[0] : -1, 272);
    check("nom_fc_abs", frame_cycles, 262);

    begin_frame("busy_start", cyc + 4);
    finish_frame("busy_start", s_cur + 20);

    dly = '{10, 30, 10, 10, 10};
    begin_frame("early", cyc + 3);
    inj_cyc[0] = exp_pulse[1] - 1;  inj_mask[0] = NS'(1) << 1;
    inj_cyc[1] = exp_pulse[1] + 5;  inj_mask[1] = NS'(1) << 3;
    finish_frame("early", 0);

    dly = '{5, 5, -1, 5, 5};
    begin_frame("tmo", cyc + 3);
    finish_frame("tmo", 0);
    check("tmo_latency", (pulse_cyc.size() > 2 && err_cyc >= 0) ? err_cyc - pulse_cyc[2] : -1, TO);

    dly = '{default: 8};
    begin_frame("recover", cyc + 2);
    finish_frame("recover", 0);

    dly = '{3, 3, TO - 1, 3, 3};
    begin_frame("coincide", cyc + 3);
    finish_frame("coincide", 0);

    dly = '{default: 120};
    begin_frame("sat", cyc + 3);
    finish_frame("sat", 0);

    dly = '{default: 40};
    begin_frame("midrst", cyc + 3);
    r = exp_pulse[3] + 5;
    wait_cycle(r);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    check("midrst_start", stage_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_idx", stage_idx, 0);
    check("midrst_end", end_flag, 0);
    check("midrst_err", error, 0);
    check("midrst_fc", frame_cycles, 0);
    wait_cycle(exp_pulse[3] + dly[3] + 5);
    check("midrst_npulse", pulse_cyc.size(), 4);
    check("midrst_nend", endf_cyc.size(), 0);
    check("midrst_busy2", busy, 0);
    check("midrst_idx2", stage_idx, 0);
    begin_frame("post_rst", cyc + 3);
    finish_frame("post_rst", 0);

    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NS; k++) begin
        dly[k] = $urandom_range(1, 40);
        if ($urandom_range(0, 7) == 0) dly[k] = TO - 1;
        if ($urandom_range(0, 11) == 0) dly[k] = -1;
      end
      begin_frame($sformatf("rnd%0d", f), cyc + $urandom_range(1, 6));
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(s_cur + 2, fin - 1) : 0;
      finish_frame($sformatf("rnd%0d", f), extra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
